// File: rtl/uart_loader.sv
// uart_loader: polls a UART for a framed byte stream (sync, address, count,
// payload), writes the assembled words to memory, then returns an ACK byte.
module uart_loader #(
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter logic [7:0] ACK_BYTE  = 8'h06
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [15:0] words_loaded,
   output logic        uart_address,
   output logic        uart_readenable,
   output logic        uart_writeenable,
   output logic [31:0] uart_writedata,
   input  logic [31:0] uart_readdata,
   output logic [31:0] mem_address,
   output logic [31:0] mem_writedata,
   output logic        mem_write,
   input  logic        mem_waitrequest
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_SMP, S_MEMWR, S_ACK_RD, S_ACK_SMP, S_ACK_WR
   } state_t;

   typedef enum logic [1:0] {P_SYNC, P_ADDR, P_COUNT, P_DATA} phase_t;

   state_t      r_state;
   phase_t      r_phase;
   logic [1:0]  r_bcnt;
   logic [31:0] r_addr;
   logic [15:0] r_count;
   logic [31:0] r_word;

   logic        w_rvalid;
   logic        w_wspace;
   logic [7:0]  w_byte;
   logic [15:0] w_cnt_next;
   logic [15:0] w_wl_next;
   logic        w_unused_rd;

   // Field decode of the registered UART read data and next-value helpers
   assign w_rvalid    = uart_readdata[15];
   assign w_wspace    = uart_readdata[16];
   assign w_byte      = uart_readdata[7:0];
   assign w_cnt_next  = {w_byte, r_count[15:8]};
   assign w_wl_next   = words_loaded + 16'd1;
   assign w_unused_rd = ^{uart_readdata[31:17], uart_readdata[14:8]};

   // Loader FSM: strobes are one-cycle pulses, every output is registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= S_IDLE;
         r_phase          <= P_SYNC;
         r_bcnt           <= 2'd0;
         r_addr           <= 32'd0;
         r_count          <= 16'd0;
         r_word           <= 32'd0;
         busy             <= 1'b0;
         done             <= 1'b0;
         words_loaded     <= 16'd0;
         uart_address     <= 1'b0;
         uart_readenable  <= 1'b0;
         uart_writeenable <= 1'b0;
         uart_writedata   <= 32'd0;
         mem_address      <= 32'd0;
         mem_writedata    <= 32'd0;
         mem_write        <= 1'b0;
      end else begin
         uart_readenable  <= 1'b0;
         uart_writeenable <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  busy            <= 1'b1;
                  done            <= 1'b0;
                  words_loaded    <= 16'd0;
                  r_phase         <= P_SYNC;
                  r_bcnt          <= 2'd0;
                  uart_address    <= 1'b0;
                  uart_readenable <= 1'b1;
                  r_state         <= S_RD;
               end
            end
            S_RD: r_state <= S_SMP;
            S_SMP: begin
               // Default: poll the data register again
               uart_address    <= 1'b0;
               uart_readenable <= 1'b1;
               r_state         <= S_RD;
               if (w_rvalid) begin
                  case (r_phase)
                     P_SYNC: begin
                        if (w_byte == SYNC_BYTE) begin
                           r_phase <= P_ADDR;
                           r_bcnt  <= 2'd0;
                        end
                     end
                     P_ADDR: begin
                        if (r_bcnt == 2'd3) begin
                           r_addr  <= {w_byte, r_addr[31:10], 2'b00};
                           r_phase <= P_COUNT;
                           r_bcnt  <= 2'd0;
                        end else begin
                           r_addr <= {w_byte, r_addr[31:8]};
                           r_bcnt <= r_bcnt + 2'd1;
                        end
                     end
                     P_COUNT: begin
                        r_count <= w_cnt_next;
                        if (r_bcnt == 2'd1) begin
                           r_bcnt <= 2'd0;
                           if (w_cnt_next == 16'd0) begin
                              uart_address <= 1'b1;
                              r_state      <= S_ACK_RD;
                           end else begin
                              r_phase <= P_DATA;
                           end
                        end else begin
                           r_bcnt <= 2'd1;
                        end
                     end
                     default: begin
                        if (r_bcnt == 2'd3) begin
                           uart_readenable <= 1'b0;
                           mem_write       <= 1'b1;
                           mem_address     <= r_addr;
                           mem_writedata   <= {w_byte, r_word[31:8]};
                           r_bcnt          <= 2'd0;
                           r_state         <= S_MEMWR;
                        end else begin
                           r_word <= {w_byte, r_word[31:8]};
                           r_bcnt <= r_bcnt + 2'd1;
                        end
                     end
                  endcase
               end
            end
            S_MEMWR: begin
               if (!mem_waitrequest) begin
                  mem_write       <= 1'b0;
                  r_addr          <= r_addr + 32'd4;
                  words_loaded    <= w_wl_next;
                  uart_readenable <= 1'b1;
                  if (w_wl_next == r_count) begin
                     uart_address <= 1'b1;
                     r_state      <= S_ACK_RD;
                  end else begin
                     uart_address <= 1'b0;
                     r_state      <= S_RD;
                  end
               end
            end
            S_ACK_RD: r_state <= S_ACK_SMP;
            S_ACK_SMP: begin
               if (w_wspace) begin
                  uart_address     <= 1'b0;
                  uart_writeenable <= 1'b1;
                  uart_writedata   <= {24'd0, ACK_BYTE};
                  r_state          <= S_ACK_WR;
               end else begin
                  uart_address    <= 1'b1;
                  uart_readenable <= 1'b1;
                  r_state         <= S_ACK_RD;
               end
            end
            S_ACK_WR: begin
               busy    <= 1'b0;
               done    <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
